// File: rtl/cache_data_nway.sv
// N-way set-associative L1 data store: per-word byte-writable banks, CPU load/store, line refill and victim read-out.
// Replacement: round-robin per set by default; tree pseudo-LRU when CACHE_DATA_PLRU_EN is defined.
module cache_data_nway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 128,
    parameter int LINE_WORDS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sram_en,
    input  logic [3:0]               sram_wen,
    input  logic [31:0]              sram_addr,
    input  logic [31:0]              sram_wdata,
    output logic [31:0]              sram_rdata,
    output logic                     rdata_valid,
    input  logic                     hit,
    input  logic [WAYS-1:0]          hit_way,
    input  logic                     cached,
    output logic [WAYS-1:0]          victim_way,
    input  logic                     refresh,
    input  logic [32*LINE_WORDS-1:0] cacheline_new,
    input  logic                     write_back,
    output logic [32*LINE_WORDS-1:0] cacheline_old
);

    localparam int INDEX_W  = $clog2(SETS);
    localparam int WORD_W   = $clog2(LINE_WORDS);
    localparam int OFFSET_W = WORD_W + 2;
    localparam int WAY_W    = $clog2(WAYS);
    localparam int BANKS    = WAYS * LINE_WORDS;

    logic [INDEX_W-1:0] idx;
    logic [WORD_W-1:0]  word;
    logic               unused_addr_bits;

    assign idx  = sram_addr[OFFSET_W +: INDEX_W];
    assign word = sram_addr[2 +: WORD_W];
    assign unused_addr_bits = ^{sram_addr[31:OFFSET_W+INDEX_W], sram_addr[1:0]};

    // Priority refresh > write-back > CPU; everything is gated while reset is held.
    logic refresh_act, wb_act, cpu_act, load_act, store_act;

    assign refresh_act = rst & refresh & cached;
    assign wb_act      = rst & write_back & ~refresh_act;
    assign cpu_act     = rst & ~refresh_act & ~write_back & sram_en & hit & cached;
    assign load_act    = cpu_act & (sram_wen == 4'b0000);
    assign store_act   = cpu_act & (sram_wen != 4'b0000);

    logic [31:0] bank_rd [BANKS];

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        localparam int W = g / LINE_WORDS;
        localparam int K = g % LINE_WORDS;

        logic [31:0] mem_q [SETS];
        logic [31:0] rd_q;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        re;

        always_comb begin
            be = '0;
            wd = sram_wdata;
            if (refresh_act && victim_way[W]) begin
                be = '1;
                wd = cacheline_new[K*32 +: 32];
            end else if (store_act && hit_way[W] && (word == WORD_W'(K))) begin
                be = sram_wen;
            end
            re = (wb_act && victim_way[W]) || (load_act && (word == WORD_W'(K)));
        end

        always_ff @(posedge clk) begin
            if (re) begin
                rd_q <= mem_q[idx];
            end
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end

        assign bank_rd[g] = rd_q;
    end

    logic              load_q;
    logic [WAYS-1:0]   hit_way_q;
    logic [WORD_W-1:0] word_q;
    logic [WAYS-1:0]   wb_way_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            load_q    <= 1'b0;
            hit_way_q <= '0;
            word_q    <= '0;
            wb_way_q  <= '0;
        end else begin
            load_q <= load_act;
            if (load_act) begin
                hit_way_q <= hit_way;
                word_q    <= word;
            end
            if (wb_act) begin
                wb_way_q <= victim_way;
            end
        end
    end

    always_comb begin
        sram_rdata = '0;
        if (load_q) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (hit_way_q[w]) begin
                    sram_rdata = sram_rdata | bank_rd[w*LINE_WORDS + int'(word_q)];
                end
            end
        end
    end

    assign rdata_valid = load_q;

    always_comb begin
        cacheline_old = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                if (wb_way_q[w]) begin
                    cacheline_old[k*32 +: 32] = cacheline_old[k*32 +: 32] | bank_rd[w*LINE_WORDS + k];
                end
            end
        end
    end

`ifdef CACHE_DATA_PLRU_EN
    // Heap-ordered tree: node n (1-based) stored at bit n-1; bit=1 means the victim lies right.
    logic [WAYS-2:0] plru_q [SETS];
    logic [WAYS-2:0] plru_d;
    logic [WAY_W-1:0] upd_way;

    function automatic logic [WAY_W-1:0] enc(input logic [WAYS-1:0] oh);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (oh[i]) begin
                r = r | WAY_W'(i);
            end
        end
        return r;
    endfunction

    always_comb begin
        int unsigned node;
        node = 1;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            node = 2*node + int'(plru_q[idx][node-1]);
        end
        victim_way = '0;
        victim_way[node-WAYS] = 1'b1;
    end

    assign upd_way = refresh_act ? enc(victim_way) : enc(hit_way);

    always_comb begin
        int unsigned n;
        plru_d = plru_q[idx];
        n = int'(upd_way) + WAYS;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            plru_d[(n >> 1) - 1] = ((n & 1) == 0);
            n = n >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else if (refresh_act || cpu_act) begin
            plru_q[idx] <= plru_d;
        end
    end
`else
    logic [WAY_W-1:0] rr_q [SETS];

    assign victim_way = {{(WAYS-1){1'b0}}, 1'b1} << rr_q[idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else if (refresh_act) begin
            rr_q[idx] <= rr_q[idx] + WAY_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cache_data_nway.sv
// Directed self-checking bench for cache_data_nway (WAYS=2, SETS=128, LINE_WORDS=8).
// Expectations follow CACHE_DATA_PLRU_EN where the replacement policy matters.
module tb_cache_data_nway;

    localparam int WAYS = 2;
    localparam int SETS = 128;
    localparam int LW   = 8;
    localparam int LINE_W = 32 * LW;

    logic              clk = 1'b0;
    logic              rst;
    logic              sram_en;
    logic [3:0]        sram_wen;
    logic [31:0]       sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;
    logic              rdata_valid;
    logic              hit;
    logic [WAYS-1:0]   hit_way;
    logic              cached;
    logic [WAYS-1:0]   victim_way;
    logic              refresh;
    logic [LINE_W-1:0] cacheline_new;
    logic              write_back;
    logic [LINE_W-1:0] cacheline_old;

    int errors = 0;
    int checks = 0;

    cache_data_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .rdata_valid(rdata_valid), .hit(hit), .hit_way(hit_way), .cached(cached),
        .victim_way(victim_way), .refresh(refresh), .cacheline_new(cacheline_new),
        .write_back(write_back), .cacheline_old(cacheline_old)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sram_en = 1'b0; sram_wen = 4'b0000; sram_wdata = '0;
        hit = 1'b0; hit_way = '0; cached = 1'b1;
        refresh = 1'b0; write_back = 1'b0; cacheline_new = '0;
    endtask

    function automatic logic [31:0] addr(input int unsigned index, input int unsigned off);
        logic [6:0] i7;
        logic [4:0] o5;
        i7 = 7'(index);
        o5 = 5'(off);
        return {20'h12345, i7, o5};
    endfunction

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < LW; k++) l[k*32 +: 32] = base | 32'(k);
        return l;
    endfunction

    task automatic load(input int unsigned index, input int unsigned off, input logic [WAYS-1:0] way);
        idle();
        sram_addr = addr(index, off);
        sram_en = 1'b1; hit = 1'b1; hit_way = way;
        tick();
        idle();
    endtask

    logic [LINE_W-1:0] exp_line;

    initial begin
        idle();
        sram_addr = addr(5, 0);
        rst = 1'b0;
        tick(); tick();
        chk("reset_rdata", 32'(sram_rdata), 0);
        chk("reset_valid", 1'(rdata_valid), 0);
        chk("reset_victim", 2'(victim_way), 2'b01);
        rst = 1'b1;

        // First refill into way 0 at index 5
        sram_addr = addr(5, 0);
        refresh = 1'b1; cacheline_new = mk_line(32'h1000_0000);
        tick();
        idle();

        load(5, 'h0C, 2'b01);
        chk("load1_data", 32'(sram_rdata), 32'h1000_0003);
        chk("load1_valid", 1'(rdata_valid), 1);

        sram_addr = addr(5, 'h0C);
        sram_en = 1'b1; sram_wen = 4'b0010; sram_wdata = 32'hAABB_CCDD;
        hit = 1'b1; hit_way = 2'b01;
        tick();
        idle();
        chk("store_valid", 1'(rdata_valid), 0);

        load(5, 'h0C, 2'b01);
        chk("store_readback", 32'(sram_rdata), 32'h1000_CC03);

        sram_addr = addr(5, 0);
        #1;
        chk("victim_before_2nd", 2'(victim_way), 2'b10);
        refresh = 1'b1; cacheline_new = mk_line(32'h2000_0000);
        tick();
        idle();

        load(5, 'h0C, 2'b10);
        chk("load_way1", 32'(sram_rdata), 32'h2000_0003);
        load(5, 'h0C, 2'b01);
        chk("load_way0", 32'(sram_rdata), 32'h1000_CC03);
        sram_addr = addr(5, 0);
        #1;
`ifdef CACHE_DATA_PLRU_EN
        chk("victim_after_hit", 2'(victim_way), 2'b10);
        load(5, 0, 2'b10);
        sram_addr = addr(5, 0);
        #1;
`else
        chk("victim_after_hit", 2'(victim_way), 2'b01);
`endif

        // Write-back of way 0 at index 5
        write_back = 1'b1;
        tick();
        idle();
        exp_line = mk_line(32'h1000_0000);
        exp_line[3*32 +: 32] = 32'h1000_CC03;
        chk("writeback_line", cacheline_old, exp_line);
        chk("writeback_valid", 1'(rdata_valid), 0);

        idle(); sram_addr = addr(5, 'h0C); sram_en = 1'b1; hit = 1'b0; hit_way = 2'b01;
        tick();
        chk("miss_rdata", 32'(sram_rdata), 0);
        chk("miss_valid", 1'(rdata_valid), 0);

        idle(); sram_addr = addr(5, 'h0C); sram_en = 1'b1; hit = 1'b1; hit_way = 2'b01; cached = 1'b0;
        tick();
        chk("uncached_rdata", 32'(sram_rdata), 0);
        chk("uncached_valid", 1'(rdata_valid), 0);

        idle(); sram_addr = addr(5, 'h0C); sram_en = 1'b1; sram_wen = 4'b1111;
        sram_wdata = 32'hFFFF_FFFF; hit = 1'b1; hit_way = 2'b01; cached = 1'b0;
        tick();
        idle();
        load(5, 'h0C, 2'b01);
        chk("uncached_store_ignored", 32'(sram_rdata), 32'h1000_CC03);

        // Refresh wins over a same-cycle store
        sram_addr = addr(7, 'h08);
        #1;
        chk("victim_idx7", 2'(victim_way), 2'b01);
        refresh = 1'b1; cacheline_new = mk_line(32'h3000_0000);
        sram_en = 1'b1; sram_wen = 4'b1111; sram_wdata = 32'hDEAD_BEEF;
        hit = 1'b1; hit_way = 2'b01;
        tick();
        idle();
        load(7, 'h08, 2'b01);
        chk("priority_refresh", 32'(sram_rdata), 32'h3000_0002);

        // Reset asserted while a load is requested
        sram_addr = addr(5, 'h0C); sram_en = 1'b1; hit = 1'b1; hit_way = 2'b01;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        idle();
        chk("midreset_rdata", 32'(sram_rdata), 0);
        chk("midreset_valid", 1'(rdata_valid), 0);
        sram_addr = addr(0, 0);   #1; chk("reset_victim_i0", 2'(victim_way), 2'b01);
        sram_addr = addr(5, 0);   #1; chk("reset_victim_i5", 2'(victim_way), 2'b01);
        sram_addr = addr(7, 0);   #1; chk("reset_victim_i7", 2'(victim_way), 2'b01);
        sram_addr = addr(127, 0); #1; chk("reset_victim_i127", 2'(victim_way), 2'b01);

        load(5, 'h0C, 2'b01);
        chk("data_kept_after_reset", 32'(sram_rdata), 32'h1000_CC03);
        chk("valid_after_reset", 1'(rdata_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_data_nway.md
# cache_data_nway

Parametrised N-way set-associative data store for the L1 caches, successor to the single-way direct-mapped data array. It holds `WAYS × SETS` cache lines in per-word banks and serves 32-bit CPU loads and stores to the hit way. It refills whole lines from the AXI side into a selected victim way and reads out the victim line for write-back. It owns per-set replacement state and sits between the tag/compare block (which supplies `hit`, `hit_way`, `cached`) and the AXI refill/write-back engine.

## Interface
- `WAYS`, 2: associativity; power of two, 2..8.
- `SETS`, 128: sets per way; power of two; `INDEX_W = log2(SETS)`.
- `LINE_WORDS`, 8: 32-bit words per line; power of two; `OFFSET_W = log2(LINE_WORDS) + 2`; `LINE_W = 32 × LINE_WORDS`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `sram_en` in 1: CPU access request.
- `sram_wen` in 4: byte write enables; 0 means read.
- `sram_addr` in 32: `{tag, index[INDEX_W], offset[OFFSET_W]}`.
- `sram_wdata` in 32: store data.
- `sram_rdata` out 32: load data, registered.
- `rdata_valid` out 1: `sram_rdata` is valid this cycle.
- `hit` in 1: tag match this cycle.
- `hit_way` in WAYS: one-hot matching way; meaningful only when `hit`=1.
- `cached` in 1: access is cacheable.
- `victim_way` out WAYS: one-hot replacement victim for the set at `sram_addr` index; combinational.
- `refresh` in 1: write `cacheline_new` into `victim_way`.
- `cacheline_new` in LINE_W: refill line, word 0 in bits [31:0].
- `write_back` in 1: read the victim line out.
- `cacheline_old` out LINE_W: victim line, same packing.

## Operation
- Storage: `WAYS × LINE_WORDS` banks of `SETS × 32` bits each. Each bank has a synchronous read, byte-write enables, and read-first behaviour. All banks are addressed by `index`. Word bank = `offset[OFFSET_W-1:2]`.
- Per-cycle priority: `refresh & cached` > `write_back` > CPU access. A lower-priority request in the same cycle is dropped; upstream stalls it.
- Refresh: all `LINE_WORDS` banks of `victim_way` at `index` are written with `cacheline_new`, all bytes. Replacement state marks that way most-recently-used.
- Write-back: all banks of `victim_way` at `index` are read. `cacheline_old` is valid the next cycle.
- CPU store (`sram_en & hit & cached & wen≠0`): writes the bytes selected by `wen` into bank `word` of `hit_way`. Marks `hit_way` MRU. `rdata_valid`=0.
- CPU load (`sram_en & hit & cached & wen=0`): reads bank `word` of all ways. The next cycle, `sram_rdata` = the word from the registered `hit_way`, and `rdata_valid`=1. Marks `hit_way` MRU.
- Any other cycle (`hit`=0, `cached`=0, `sram_en`=0, or the access was dropped): the next cycle, `sram_rdata`=0 and `rdata_valid`=0.
- `hit_way` that is not one-hot while `hit`=1 is illegal; the output is undefined.
- `victim_way` may change only on a refresh or a hit access. The sequence write_back → refresh for one miss therefore targets the same way, provided no hit access to that set intervenes.

## Timing
- Load latency: 1 cycle from the request edge to `sram_rdata`/`rdata_valid`.
- Write-back latency: 1 cycle to `cacheline_old`.
- `cacheline_old` holds the last bank outputs until the next bank read.
- Refresh and store each take 1 cycle; back-to-back requests are accepted every cycle.
- `victim_way` reflects replacement updates made at the previous edge.
- A load the cycle after a store or refresh to the same word returns the new data.
- Reset (`rst`=0 at an edge):
  - `sram_rdata`=0, `rdata_valid`=0.
  - Registered `hit_way`/`word` are cleared.
  - All replacement state is cleared, so `victim_way` = way 0 (`1`) for every set.
  - Data banks are not cleared.
  - Reset mid-refresh or mid-write-back aborts the operation; the partially updated line is undefined.

## Configuration
- `CACHE_DATA_PLRU_EN` defined:
  - Tree pseudo-LRU with `WAYS-1` bits per set, updated on every hit access and refresh.
  - The victim is the way the tree points away from.
- `CACHE_DATA_PLRU_EN` undefined:
  - Per-set round-robin pointer of `log2(WAYS)` bits, which advances only on refresh.
  - Hit accesses do not change replacement state.
  - `victim_way` = one-hot(pointer).

## Test plan
All scenarios use `WAYS`=2, `SETS`=128, `LINE_WORDS`=8.
- Refresh at index 5 with word k = `0x1000_000k`: `victim_way`=`01` before. Then load offset `0x0C` with `hit_way`=`01` → next cycle `sram_rdata`=`0x1000_0003`, `rdata_valid`=1.
- Store `wen`=`0010`, `wdata`=`0xAABBCCDD` to that word, then load it → `0x1000_CC03`.
- Second refresh at index 5 → goes to way 1 (`victim_way`=`10`). Then load way 0, then read `victim_way`:
  - Round-robin: `01`.
  - `CACHE_DATA_PLRU_EN`: `10`.
- Write-back at index 5 with victim way 0 → next cycle `cacheline_old` equals the stored line, including the byte-modified word.
- Load with `hit`=0, and separately with `cached`=0 → `sram_rdata`=0, `rdata_valid`=0. A store under `cached`=0 leaves the data unchanged on re-read.
- Drive `rst`=0 for one cycle mid-stream → `sram_rdata`=0 and `victim_way`=`01` for every index. A subsequent load of index 5 way 0 still returns `0x1000_CC03`.
